// File: rtl/packages_fsm.sv
// Shared types and constants for the memory access controller and its wait counter.
package packages_fsm;

  localparam int unsigned MAX_WAIT = 15;

  typedef enum logic [1:0] {
    NOP   = 2'd0,
    FETCH = 2'd1,
    WRITE = 2'd2
  } inst_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    STORE = 3'd2,
    WAITE = 3'd3,
    RESP  = 3'd4
  } state_t;

  // A zero-wait build still needs a one-bit counter to keep the vector legal.
  function automatic int unsigned cntWidth(input int unsigned waitCycles);
    return (waitCycles > 0) ? $clog2(waitCycles + 1) : 1;
  endfunction

endpackage

// File: rtl/mem_wait_cnt.sv
// Wait-state counter: loaded with WAIT_CYCLES, counts down, flags the final wait cycle.
module mem_wait_cnt
  import packages_fsm::*;
#(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic clock,
  input  logic resetN,
  input  logic i_load,
  input  logic i_dec,
  output logic o_last
);

  localparam int unsigned CNT_W = cntWidth(WAIT_CYCLES);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= CNT_W'(WAIT_CYCLES);
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign o_last = (r_count == CNT_W'(1));

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store controller with programmable wait states and a one-cycle response.
// Define MEM_CTRL_PIPE_EN to accept the next request during the response cycle.
module mem_access_ctrl
  import packages_fsm::*;
#(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clock,
  input  logic              resetN,
  input  logic              req_valid,
  output logic              req_ready,
  input  inst_t             req_inst,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              busy
);

`ifdef MEM_CTRL_PIPE_EN
  localparam bit PIPE_EN = 1'b1;
`else
  localparam bit PIPE_EN = 1'b0;
`endif

  if (WAIT_CYCLES > MAX_WAIT) begin : g_badWait
    $error("mem_access_ctrl: WAIT_CYCLES exceeds MAX_WAIT");
  end

  state_t            r_state;
  state_t            w_nextState;
  state_t            w_acceptState;
  inst_t             r_inst;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_respRdata;
  logic              r_memRead;
  logic              r_memWrite;
  logic              r_respValid;
  logic              r_busy;
  logic              r_reqReady;
  logic              w_accept;
  logic              w_last;
  logic              w_lastStrobe;
  logic              w_readyNext;

  mem_wait_cnt #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_waitCnt (
    .clock  (clock),
    .resetN (resetN),
    .i_load ((r_state == LOAD) || (r_state == STORE)),
    .i_dec  (r_state == WAITE),
    .o_last (w_last)
  );

  // NOP and the unused encoding are accepted but lead straight back to IDLE.
  always_comb begin
    w_acceptState = IDLE;
    case (req_inst)
      FETCH:   w_acceptState = LOAD;
      WRITE:   w_acceptState = STORE;
      default: w_acceptState = IDLE;
    endcase
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:        if (req_valid) w_nextState = w_acceptState;
      LOAD, STORE: w_nextState = (WAIT_CYCLES > 0) ? WAITE : RESP;
      WAITE:       if (w_last) w_nextState = RESP;
      RESP:        w_nextState = (PIPE_EN && req_valid) ? w_acceptState : IDLE;
      default:     w_nextState = IDLE;
    endcase
  end

  assign w_accept     = req_valid && r_reqReady;
  assign w_lastStrobe = ((r_state == LOAD) || (r_state == STORE) || (r_state == WAITE))
                        && (w_nextState == RESP);
  assign w_readyNext  = (w_nextState == IDLE) || (PIPE_EN && (w_nextState == RESP));

  // Outputs are registered from the next state so they change only on an edge or reset.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_state     <= IDLE;
      r_inst      <= NOP;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_respRdata <= '0;
      r_memRead   <= 1'b0;
      r_memWrite  <= 1'b0;
      r_respValid <= 1'b0;
      r_busy      <= 1'b0;
      r_reqReady  <= 1'b1;
    end else begin
      r_state <= w_nextState;
      if (w_accept) begin
        r_inst  <= req_inst;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
      end
      if (w_lastStrobe && (r_inst == FETCH)) begin
        r_respRdata <= mem_rdata;
      end
      r_memRead   <= (w_nextState == LOAD)  || ((w_nextState == WAITE) && (r_inst == FETCH));
      r_memWrite  <= (w_nextState == STORE) || ((w_nextState == WAITE) && (r_inst == WRITE));
      r_respValid <= (w_nextState == RESP);
      r_busy      <= (w_nextState != IDLE);
      r_reqReady  <= w_readyNext;
    end
  end

  assign req_ready  = r_reqReady;
  assign mem_addr   = r_addr;
  assign mem_wdata  = r_wdata;
  assign mem_read   = r_memRead;
  assign mem_write  = r_memWrite;
  assign resp_valid = r_respValid;
  assign resp_rdata = r_respRdata;
  assign busy       = r_busy;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: one instance with two wait states, one with none.
module tb_mem_access_ctrl;
  import packages_fsm::*;

  logic        clock    = 1'b0;
  logic        resetN   = 1'b0;
  logic        valid2   = 1'b0;
  logic        valid0   = 1'b0;
  inst_t       reqInst  = NOP;
  logic [7:0]  reqAddr  = '0;
  logic [15:0] reqWdata = '0;
  logic [15:0] memRdata = '0;
  logic        useZero  = 1'b0;

  logic        ready2, read2, write2, resp2, busy2;
  logic        ready0, read0, write0, resp0, busy0;
  logic [7:0]  addr2, addr0;
  logic [15:0] wdata2, wdata0, rdata2, rdata0;

  logic        selReady, selRead, selWrite, selResp, selBusy;
  logic [7:0]  selAddr;
  logic [15:0] selWdata, selRdata;

  int nAsserts = 0;
  int nFails   = 0;

  always #5 clock = ~clock;

  mem_access_ctrl #(.ADDR_W(8), .DATA_W(16), .WAIT_CYCLES(2)) dut2 (
    .clock(clock), .resetN(resetN), .req_valid(valid2), .req_ready(ready2),
    .req_inst(reqInst), .req_addr(reqAddr), .req_wdata(reqWdata),
    .mem_addr(addr2), .mem_wdata(wdata2), .mem_rdata(memRdata),
    .mem_read(read2), .mem_write(write2), .resp_valid(resp2),
    .resp_rdata(rdata2), .busy(busy2)
  );

  mem_access_ctrl #(.ADDR_W(8), .DATA_W(16), .WAIT_CYCLES(0)) dut0 (
    .clock(clock), .resetN(resetN), .req_valid(valid0), .req_ready(ready0),
    .req_inst(reqInst), .req_addr(reqAddr), .req_wdata(reqWdata),
    .mem_addr(addr0), .mem_wdata(wdata0), .mem_rdata(memRdata),
    .mem_read(read0), .mem_write(write0), .resp_valid(resp0),
    .resp_rdata(rdata0), .busy(busy0)
  );

  assign selReady = useZero ? ready0 : ready2;
  assign selRead  = useZero ? read0  : read2;
  assign selWrite = useZero ? write0 : write2;
  assign selResp  = useZero ? resp0  : resp2;
  assign selBusy  = useZero ? busy0  : busy2;
  assign selAddr  = useZero ? addr0  : addr2;
  assign selWdata = useZero ? wdata0 : wdata2;
  assign selRdata = useZero ? rdata0 : rdata2;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one request for one edge, then scramble the inputs so later use of them shows up.
  task automatic applyStimulus(input logic toZero, input inst_t inst,
                               input logic [7:0] addr, input logic [15:0] wdata);
    useZero  = toZero;
    reqInst  = inst;
    reqAddr  = addr;
    reqWdata = wdata;
    if (toZero) valid0 = 1'b1;
    else        valid2 = 1'b1;
    tick();
    valid0   = 1'b0;
    valid2   = 1'b0;
    reqAddr  = ~addr;
    reqWdata = ~wdata;
    reqInst  = (inst == FETCH) ? WRITE : FETCH;
  endtask

  task automatic measureTxn(input logic [7:0] expAddr, input logic [15:0] expWdata,
                            output int strobes, output int edges, output logic windowOk,
                            output logic sawRead, output logic sawWrite);
    strobes  = 0;
    edges    = 1;
    windowOk = 1'b1;
    sawRead  = 1'b0;
    sawWrite = 1'b0;
    while (!selResp && edges < 30) begin
      if (selRead || selWrite) begin
        strobes++;
        if (selAddr !== expAddr) windowOk = 1'b0;
        if (selWrite && (selWdata !== expWdata)) windowOk = 1'b0;
      end
      if (selRead && selWrite) windowOk = 1'b0;
      if (selRead)  sawRead  = 1'b1;
      if (selWrite) sawWrite = 1'b1;
      tick();
      edges++;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    int   strobes, edges, respCount, cyc, first, second;
    logic ok, sawR, sawW, readyAtResp;

    // Reset state
    #12;
    checkOutput("reset_ready",  32'(ready2), 32'd1);
    checkOutput("reset_busy",   32'(busy2),  32'd0);
    checkOutput("reset_read",   32'(read2),  32'd0);
    checkOutput("reset_write",  32'(write2), 32'd0);
    checkOutput("reset_resp",   32'(resp2),  32'd0);
    checkOutput("reset_rdata",  32'(rdata2), 32'd0);
    checkOutput("reset_ready0", 32'(ready0), 32'd1);
    resetN = 1'b1;
    tick();
    checkOutput("idle_ready", 32'(ready2), 32'd1);

    // FETCH with two wait states
    memRdata = 16'hBEEF;
    applyStimulus(1'b0, FETCH, 8'h3C, 16'h0000);
    measureTxn(8'h3C, 16'h0000, strobes, edges, ok, sawR, sawW);
    checkOutput("fetch_strobe_cycles", 32'(strobes), 32'd3);
    checkOutput("fetch_latency_edges", 32'(edges),   32'd4);
    checkOutput("fetch_window",        32'(ok),      32'd1);
    checkOutput("fetch_saw_read",      32'(sawR),    32'd1);
    checkOutput("fetch_saw_write",     32'(sawW),    32'd0);
    checkOutput("fetch_resp_valid",    32'(selResp), 32'd1);
    checkOutput("fetch_resp_rdata",    32'(selRdata), 32'hBEEF);
    checkOutput("fetch_resp_strobes",  32'({selRead, selWrite}), 32'd0);
    checkOutput("fetch_resp_ready",    32'(selReady), 32'd0);
    tick();
    checkOutput("fetch_resp_pulse", 32'(selResp),  32'd0);
    checkOutput("fetch_done_busy",  32'(selBusy),  32'd0);
    checkOutput("fetch_done_ready", 32'(selReady), 32'd1);

    // Zero wait states: FETCH then WRITE, the WRITE must keep the earlier read data
    memRdata = 16'hA5A5;
    applyStimulus(1'b1, FETCH, 8'h20, 16'h0000);
    measureTxn(8'h20, 16'h0000, strobes, edges, ok, sawR, sawW);
    checkOutput("w0_fetch_strobe_cycles", 32'(strobes), 32'd1);
    checkOutput("w0_fetch_latency_edges", 32'(edges),   32'd2);
    checkOutput("w0_fetch_rdata",         32'(selRdata), 32'hA5A5);
    tick();
    memRdata = 16'h7777;
    applyStimulus(1'b1, WRITE, 8'h10, 16'h1234);
    measureTxn(8'h10, 16'h1234, strobes, edges, ok, sawR, sawW);
    checkOutput("write_strobe_cycles", 32'(strobes), 32'd1);
    checkOutput("write_latency_edges", 32'(edges),   32'd2);
    checkOutput("write_window",        32'(ok),      32'd1);
    checkOutput("write_saw_write",     32'(sawW),    32'd1);
    checkOutput("write_saw_read",      32'(sawR),    32'd0);
    checkOutput("write_resp_valid",    32'(selResp), 32'd1);
    checkOutput("write_rdata_kept",    32'(selRdata), 32'hA5A5);
    tick();
    checkOutput("write_done_busy", 32'(selBusy), 32'd0);

    // NOP and the illegal encoding are swallowed
    respCount = 0;
    applyStimulus(1'b0, NOP, 8'h44, 16'h0000);
    checkOutput("nop_busy",    32'(selBusy),  32'd0);
    checkOutput("nop_ready",   32'(selReady), 32'd1);
    checkOutput("nop_strobes", 32'({selRead, selWrite}), 32'd0);
    for (int i = 0; i < 3; i++) begin
      if (selResp) respCount++;
      tick();
    end
    applyStimulus(1'b0, inst_t'(2'd3), 8'h45, 16'h0000);
    checkOutput("illegal_busy",    32'(selBusy), 32'd0);
    checkOutput("illegal_strobes", 32'({selRead, selWrite}), 32'd0);
    for (int i = 0; i < 3; i++) begin
      if (selResp || selRead || selWrite) respCount++;
      tick();
    end
    checkOutput("nop_illegal_no_activity", 32'(respCount), 32'd0);

    // Asynchronous reset in the middle of a FETCH wait state
    memRdata = 16'hCAFE;
    applyStimulus(1'b0, FETCH, 8'h66, 16'h0000);
    tick();
    checkOutput("abort_read_before", 32'(selRead), 32'd1);
    #2;
    resetN = 1'b0;
    #1;
    checkOutput("abort_read_dropped", 32'(selRead),  32'd0);
    checkOutput("abort_busy",         32'(selBusy),  32'd0);
    checkOutput("abort_ready",        32'(selReady), 32'd1);
    checkOutput("abort_rdata_clear",  32'(selRdata), 32'd0);
    tick();
    resetN = 1'b1;
    respCount = 0;
    for (int i = 0; i < 6; i++) begin
      if (selResp || selRead) respCount++;
      tick();
    end
    checkOutput("abort_no_resp", 32'(respCount), 32'd0);
    memRdata = 16'h1357;
    applyStimulus(1'b0, FETCH, 8'h77, 16'h0000);
    measureTxn(8'h77, 16'h0000, strobes, edges, ok, sawR, sawW);
    checkOutput("recover_strobe_cycles", 32'(strobes), 32'd3);
    checkOutput("recover_latency_edges", 32'(edges),   32'd4);
    checkOutput("recover_rdata",         32'(selRdata), 32'h1357);
    tick();

    // Back-to-back FETCHes with valid held high
    memRdata = 16'h4242;
    useZero  = 1'b0;
    reqInst  = FETCH;
    reqAddr  = 8'h5A;
    valid2   = 1'b1;
    tick();
    cyc = 0;
    first = -1;
    second = -1;
    readyAtResp = 1'b0;
    while (second < 0 && cyc < 40) begin
      if (selResp) begin
        if (first < 0) begin
          first = cyc;
          readyAtResp = selReady;
        end else begin
          second = cyc;
        end
      end
      if (second < 0) begin
        tick();
        cyc++;
      end
    end
    valid2 = 1'b0;
    checkOutput("b2b_first_latency", 32'(first), 32'd3);
`ifdef MEM_CTRL_PIPE_EN
    checkOutput("b2b_resp_spacing", 32'(second - first), 32'd4);
    checkOutput("b2b_ready_in_resp", 32'(readyAtResp), 32'd1);
`else
    checkOutput("b2b_resp_spacing", 32'(second - first), 32'd5);
    checkOutput("b2b_ready_in_resp", 32'(readyAtResp), 32'd0);
`endif
    checkOutput("b2b_rdata", 32'(selRdata), 32'h4242);
    tick();
    tick();
    checkOutput("b2b_drained_busy", 32'(selBusy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
